seq_inst_loader: RTL and testbench
==================================

Name: seq_inst_loader

Overview:
- Front end for the sequencer: the receive-side counterpart of the sequencer's UART transmit path.
- Takes bytes from the UART receiver and assembles them MSB-first into INST_WIDTH-bit instructions.
- Buffers complete instructions in a small FIFO and issues them one per cycle on the sequencer's i_inst/i_inst_valid interface.
- Holds send-type instructions while the UART transmitter is busy, so no send is dropped.

Parameters:
- INST_WIDTH, 16, instruction width in bits; must be a multiple of 8.
- OP_WIDTH, 2, opcode field width; the opcode is inst[INST_WIDTH-1 -: OP_WIDTH].
- OP_SEND, 2'd1, opcode value of the send instruction.
- FIFO_DEPTH, 4, instruction FIFO entries; power of 2, at least 2.
- SEND_GAP, 2, minimum cycles between two issued send instructions.
- TIMEOUT_CYC, 1024, inter-byte timeout in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- i_rx_data  in  8  received UART byte.
- i_rx_valid  in  1  single-cycle strobe, i_rx_data valid.
- i_tx_busy  in  1  UART transmitter busy; same signal the sequencer sees.
- o_inst  out  INST_WIDTH  instruction to the sequencer.
- o_inst_valid  out  1  instruction valid, single cycle per instruction.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_overflow  out  1  sticky: a complete instruction was dropped because the FIFO was full.

Behaviour:
- Reset (rst low, asynchronous): o_inst=0, o_inst_valid=0, o_fifo_level=0, o_overflow=0, byte counter=0, shift register=0, gap counter=0. o_overflow clears only on reset.
- Assembly:
  - NB = INST_WIDTH/8 bytes per instruction; the first byte received is bits [INST_WIDTH-1:INST_WIDTH-8].
  - Each i_rx_valid shifts the byte in and increments the byte counter.
  - On the NB-th byte the counter wraps to 0 and the assembled word is pushed into the FIFO in the same cycle. The entry becomes readable the next cycle.
- Overflow: if a push is due and the FIFO is full (and no pop happens that cycle), the word is discarded and o_overflow is set. Assembly continues normally.
- Simultaneous push and pop with the FIFO full: the push succeeds and the level is unchanged.
- Issue FSM, states IDLE, ISSUE, GAP:
  - IDLE: if the FIFO is not empty and the head is issuable, go to ISSUE.
  - Head is issuable if opcode != OP_SEND, or (opcode == OP_SEND, i_tx_busy == 0, and the gap counter is 0).
  - ISSUE: drive o_inst=head and o_inst_valid=1 for exactly one cycle, and pop.
    - If the issued word was a send, load the gap counter with SEND_GAP and go to GAP.
    - Otherwise go to IDLE. Back-to-back non-send instructions therefore issue every 2 cycles.
  - GAP: decrement the gap counter; go to IDLE when it reaches 0. Non-send instructions are not issued during GAP.
- o_inst holds its last value when o_inst_valid is 0.
- Latency: with the FIFO empty and the FSM in IDLE, the last byte strobe at cycle N gives o_inst_valid at cycle N+2.
- Ordering: strict FIFO order. A blocked send blocks all later instructions (no bypass).
- i_tx_busy rising in the same cycle the FSM evaluates IDLE: the send is not issued. Evaluation uses the current-cycle i_tx_busy.
- Reset mid-assembly or mid-issue: all partial bytes and FIFO contents are lost, with no spurious o_inst_valid.

Optional Feature:
- Macro: SEQ_LOADER_TIMEOUT_EN.
- Defined:
  - A counter runs while the byte counter is nonzero and restarts on each i_rx_valid.
  - When it reaches TIMEOUT_CYC, the byte counter clears and the partial word is discarded without setting o_overflow.
  - A byte arriving in the same cycle as the timeout is treated as byte 0 of a new instruction.
- Undefined: no timeout logic. A partial word waits indefinitely for its remaining bytes.

Test Plan:
- Bytes 0x4A,0x05 on consecutive i_rx_valid cycles, i_tx_busy=0 -> o_inst=16'h4A05 with o_inst_valid for one cycle, 2 cycles after the 0x05 strobe; o_fifo_level returns to 0.
- Send word 0x4000 (op=1) queued while i_tx_busy=1 for 20 cycles, then non-send 0x8123 queued -> nothing issues until i_tx_busy falls; then 0x4000 issues, then 0x8123 issues once the GAP state ends (in order).
- Two send words 0x4000,0x4100 queued, i_tx_busy held 0 -> issue cycles separated by at least 1+SEND_GAP=3 cycles.
- With i_tx_busy=1 and the head a send, push 5 complete instructions (FIFO_DEPTH=4) -> o_fifo_level=4, o_overflow=1 after the 5th; after release, only the first 4 words issue, in order.
- Reset asserted after 1 byte of 2, then bytes 0x12,0x34 -> o_inst=16'h1234 (the stale byte is gone) and o_overflow=0.
- SEQ_LOADER_TIMEOUT_EN defined, TIMEOUT_CYC=16: byte 0xAA, idle 16 cycles, then 0x12,0x34 -> only 16'h1234 issues. With the macro undefined, the same stimulus issues 16'hAA12.

Source files
------------

// File: rtl/seq_inst_loader.sv
// Byte-to-instruction loader: assembles UART bytes MSB-first, buffers whole words in a FIFO
// and issues them to the sequencer, pacing sends against i_tx_busy. Optional: SEQ_LOADER_TIMEOUT_EN.
module seq_inst_loader #(
    parameter int                  INST_WIDTH  = 16,
    parameter int                  OP_WIDTH    = 2,
    parameter logic [OP_WIDTH-1:0] OP_SEND     = OP_WIDTH'(1),
    parameter int                  FIFO_DEPTH  = 4,
    parameter int                  SEND_GAP    = 2
`ifdef SEQ_LOADER_TIMEOUT_EN
    ,
    parameter int                  TIMEOUT_CYC = 1024
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    i_rx_data,
    input  logic                          i_rx_valid,
    input  logic                          i_tx_busy,
    output logic [INST_WIDTH-1:0]         o_inst,
    output logic                          o_inst_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow
);

    localparam int NB  = INST_WIDTH / 8;
    localparam int BCW = $clog2(NB + 1);
    localparam int SW  = (INST_WIDTH > 8) ? INST_WIDTH - 8 : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int GW  = $clog2(SEND_GAP + 2);

    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);
    localparam logic [LW-1:0]  DEPTH_L   = LW'(FIFO_DEPTH);
    localparam logic [GW-1:0]  GAP_L     = GW'(SEND_GAP);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [SW-1:0]         shift_q, shift_d;
    logic [INST_WIDTH-1:0] word_in;
    logic [BCW-1:0]        byte_base;
    logic                  push_due, push, pop, timeout;

    logic [INST_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [INST_WIDTH-1:0] head;
    logic                  head_is_send, issuable;

    state_t                state_q, state_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;

    // The shift register keeps only the NB-1 older bytes; the newest byte completes the word.
    generate
        if (NB == 1) begin : g_single_byte
            assign word_in = i_rx_data;
        end else begin : g_multi_byte
            assign word_in = {shift_q, i_rx_data};
        end
    endgenerate

`ifdef SEQ_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_L = TW'(TIMEOUT_CYC);

    logic [TW-1:0] to_cnt_q, to_cnt_d;

    assign timeout = (byte_cnt_q != '0) && (to_cnt_q == TO_L);

    always_comb begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (i_rx_valid || (byte_cnt_q == '0) || timeout) begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // A byte landing in the timeout cycle starts a fresh word.
    assign byte_base = timeout ? '0 : byte_cnt_q;
    assign push_due  = i_rx_valid && (byte_base == LAST_BYTE);
    assign pop       = (state_q == ISSUE);
    assign push      = push_due && ((level_q != DEPTH_L) || pop);

    always_comb begin
        byte_cnt_d = byte_base;
        shift_d    = shift_q;
        if (i_rx_valid) begin
            byte_cnt_d = push_due ? '0 : byte_base + BCW'(1);
            shift_d    = word_in[SW-1:0];
        end
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = overflow_q | (push_due & ~push);
        level_d    = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word_in;
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign head_is_send = (head[INST_WIDTH-1 -: OP_WIDTH] == OP_SEND);
    assign issuable     = !head_is_send || (!i_tx_busy && (gap_q == '0));

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        inst_d  = inst_q;
        case (state_q)
            IDLE: begin
                if ((level_q != '0) && issuable) begin
                    state_d = ISSUE;
                    inst_d  = head;
                end
            end
            ISSUE: begin
                if (head_is_send) begin
                    gap_d   = GAP_L;
                    state_d = GAP;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end
                if (gap_q <= GW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            gap_q      <= '0;
            inst_q     <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            gap_q      <= gap_d;
            inst_q     <= inst_d;
        end
    end

    assign o_inst       = inst_q;
    assign o_inst_valid = (state_q == ISSUE);
    assign o_fifo_level = level_q;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_seq_inst_loader.sv
// Scoreboard bench for seq_inst_loader: a rule-level model predicts each issued word and its
// cycle, plus level/overflow; a separate monitor compares the DUT every cycle.
module tb_seq_inst_loader;

    localparam int IW    = 16;
    localparam int OPW   = 2;
    localparam int OPS   = 1;
    localparam int DEPTH = 4;
    localparam int GAP   = 2;
    localparam int NB    = IW / 8;
`ifdef SEQ_LOADER_TIMEOUT_EN
    localparam int TO    = 16;
`endif

    logic          clk;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          tx_busy;
    logic [IW-1:0] o_inst;
    logic          o_inst_valid;
    logic [2:0]    o_fifo_level;
    logic          o_overflow;

    seq_inst_loader #(
        .INST_WIDTH (IW),
        .OP_WIDTH   (OPW),
        .OP_SEND    (2'd1),
        .FIFO_DEPTH (DEPTH),
        .SEND_GAP   (GAP)
`ifdef SEQ_LOADER_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(TO)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .i_tx_busy   (tx_busy),
        .o_inst      (o_inst),
        .o_inst_valid(o_inst_valid),
        .o_fifo_level(o_fifo_level),
        .o_overflow  (o_overflow)
    );

    typedef struct {
        logic [IW-1:0] word;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [IW-1:0] m_fifo[$];
    logic [7:0]    m_bytes[$];
    logic          m_ov = 1'b0;
    int            m_issue_cyc = -1;
    int            m_ready_cyc = 0;
`ifdef SEQ_LOADER_TIMEOUT_EN
    int            m_last_byte = 0;
`endif
    logic [IW-1:0] m_w;

    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    logic [IW-1:0] exp_last = '0;
    int            last_send_c = -100;
    exp_t          e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model, evaluated mid-cycle: decides what the coming clock edge does.
    always @(negedge clk) begin
        if (!rst) begin
            m_fifo.delete();
            m_bytes.delete();
            exp_q.delete();
            m_ov        = 1'b0;
            m_issue_cyc = -1;
            m_ready_cyc = 0;
        end else begin
            if (m_fifo.size() > 0 && cyc >= m_ready_cyc) begin
                m_w = m_fifo[0];
                if (m_w[IW-1 -: OPW] != OPS || !tx_busy) begin
                    exp_q.push_back('{m_w, cyc + 1});
                    m_issue_cyc = cyc + 1;
                    m_ready_cyc = cyc + 2 + ((m_w[IW-1 -: OPW] == OPS) ? GAP : 0);
                end
            end
            if (cyc == m_issue_cyc) void'(m_fifo.pop_front());
`ifdef SEQ_LOADER_TIMEOUT_EN
            if (m_bytes.size() > 0 && cyc - m_last_byte == TO + 1) m_bytes.delete();
            if (rx_valid) m_last_byte = cyc;
`endif
            if (rx_valid) begin
                m_bytes.push_back(rx_data);
                if (m_bytes.size() == NB) begin
                    m_w = '0;
                    foreach (m_bytes[k]) m_w = {m_w[IW-9:0], m_bytes[k]};
                    m_bytes.delete();
                    if (m_fifo.size() < DEPTH) m_fifo.push_back(m_w);
                    else m_ov = 1'b1;
                end
            end
        end
    end

    // Monitor: samples DUT outputs just after each edge.
    always begin
        @(posedge clk);
        #2;
        if (!rst) begin
            check("rst_valid", o_inst_valid, 0);
            check("rst_level", o_fifo_level, 0);
            check("rst_overflow", o_overflow, 0);
            check("rst_inst", o_inst, 0);
            exp_last    = '0;
            last_send_c = -100;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("valid", o_inst_valid, 1);
                check("inst", o_inst, e.word);
                exp_last = e.word;
                $display("issue cyc=%0d inst=%h expected=%h level=%0d", cyc, o_inst, e.word, o_fifo_level);
            end else begin
                check("no_valid", o_inst_valid, 0);
            end
            if (o_inst_valid && o_inst[IW-1 -: OPW] == OPS) begin
                check("send_gap", int'((cyc - last_send_c) >= 1 + GAP), 1);
                last_send_c = cyc;
            end
            check("hold", o_inst, exp_last);
            check("level", o_fifo_level, m_fifo.size());
            check("overflow", o_overflow, m_ov);
        end
    end

    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_busy  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Basic assembly and latency
        step(1'b1, 8'h4A); step(1'b1, 8'h05); idle(8);

        // Send held by busy, non-send queued behind it
        tx_busy = 1'b1;
        step(1'b1, 8'h40); step(1'b1, 8'h00); idle(20);
        step(1'b1, 8'h81); step(1'b1, 8'h23); idle(5);
        tx_busy = 1'b0;
        idle(12);

        // Two sends back to back
        step(1'b1, 8'h40); step(1'b1, 8'h00); step(1'b1, 8'h41); step(1'b1, 8'h00); idle(12);

        // Overflow: five words while a send head is blocked
        tx_busy = 1'b1;
        step(1'b1, 8'h40); step(1'b1, 8'h00);
        for (int k = 1; k < 5; k++) begin
            step(1'b1, 8'(k)); step(1'b1, 8'(k));
        end
        idle(4);
        tx_busy = 1'b0;
        idle(20);

        // Reset mid-assembly
        step(1'b1, 8'h77);
        do_reset();
        step(1'b1, 8'h12); step(1'b1, 8'h34); idle(6);

        // Inter-byte gap (timeout behaviour depends on build)
        step(1'b1, 8'hAA); idle(16);
        step(1'b1, 8'h12); step(1'b1, 8'h34); idle(6);

        // Randomized traffic with one reset in the middle
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(15) == 0) tx_busy = ~tx_busy;
            if (i == 200) rst = 1'b0;
            if (i == 202) rst = 1'b1;
            step($urandom_range(2) == 0, 8'($urandom));
        end
        tx_busy = 1'b0;
        idle(60);

        check("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
